matmul_seq_ctrl: RTL

Sequencer for the 4-lane multiply-accumulate ALU.
- Accepts a 4x8 byte input matrix as a valid/ready stream and writes it into the X row buffer.
- Drives ALU_en in four 8-cycle accumulation groups, each followed by one clear cycle.
- Captures the four 18-bit MU results per group and writes all 16 results to the result RAM, then pulses done.
- Sits between the top-level controller/input interface and the ALU + result memory.

---
 rtl/mm_pkg.sv | 26 ++
 rtl/mm_result_writer.sv | 51 +++++
 rtl/matmul_seq_ctrl.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mm_pkg
// Description : Shared constants and state encoding for the MAC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mm_pkg;

   localparam int MM_DATA_W = 8;
   localparam int MM_MU_W   = 18;
   localparam int MM_ROWS   = 4;
   localparam int MM_COLS   = 8;
   localparam int MM_GROUPS = 4;
   localparam int MM_RES_AW = $clog2(MM_ROWS * MM_GROUPS);
   localparam int MM_IDX_W  = $clog2(MM_ROWS * MM_COLS);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_COMPUTE = 3'd2,
      S_FLUSH   = 3'd3,
      S_DONE    = 3'd4
   } mm_state_t;

endpackage
`default_nettype wire

// File: rtl/mm_result_writer.sv
`default_nettype none
// ============================================================================
// Module      : mm_result_writer
// Description : Holds one group of captured lane results and streams them
//               to the result RAM, one lane per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mm_result_writer
   import mm_pkg::*;
#(
   parameter int MU_W = MM_MU_W
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cap_en,
   input  logic [1:0]                     cap_grp,
   input  logic [MM_ROWS-1:0][MU_W-1:0]   cap_data,
   output logic                           res_we,
   output logic [MM_RES_AW-1:0]           res_addr,
   output logic [MU_W-1:0]                res_wdata
);

   logic [MU_W-1:0] r_cap [MM_ROWS];
   logic [1:0]      r_ptr;
   logic [1:0]      r_grp;
   logic            r_active;

   // A new capture can only arrive well after the previous four writes end.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MM_ROWS; i++) r_cap[i] <= '0;
         r_ptr    <= 2'd0;
         r_grp    <= 2'd0;
         r_active <= 1'b0;
      end else if (cap_en) begin
         for (int i = 0; i < MM_ROWS; i++) r_cap[i] <= cap_data[i];
         r_ptr    <= 2'd0;
         r_grp    <= cap_grp;
         r_active <= 1'b1;
      end else if (r_active) begin
         r_ptr <= r_ptr + 2'd1;
         if (r_ptr == 2'd3) r_active <= 1'b0;
      end
   end

   assign res_we    = r_active;
   assign res_addr  = r_active ? {r_grp, r_ptr} : '0;
   assign res_wdata = r_active ? r_cap[r_ptr] : '0;

endmodule
`default_nettype wire

// File: rtl/matmul_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : matmul_seq_ctrl
// Description : Loads a 4x8 byte matrix, runs four 8-cycle MAC groups on the
//               4-lane ALU and writes the 16 results to the result RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_seq_ctrl
   import mm_pkg::*;
#(
   parameter int DATA_W = MM_DATA_W,
   parameter int MU_W   = MM_MU_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 in_valid,
   input  logic [DATA_W-1:0]    in_data,
   output logic                 in_ready,
   output logic                 buf_we,
   output logic [1:0]           buf_row,
   output logic [2:0]           buf_col,
   output logic [DATA_W-1:0]    buf_wdata,
   output logic                 alu_en,
   input  logic                 four_results_ready,
   input  logic [MU_W-1:0]      mu1,
   input  logic [MU_W-1:0]      mu2,
   input  logic [MU_W-1:0]      mu3,
   input  logic [MU_W-1:0]      mu4,
   output logic                 res_we,
   output logic [MM_RES_AW-1:0] res_addr,
   output logic [MU_W-1:0]      res_wdata,
   output logic                 busy,
   output logic                 done,
   output logic                 seq_err
);

   localparam logic [MM_IDX_W-1:0] c_last_idx   = MM_IDX_W'(MM_ROWS * MM_COLS - 1);
   localparam logic [3:0]          c_ph_last    = 4'(MM_COLS);
   localparam logic [3:0]          c_ph_chk     = 4'(MM_COLS - 1);
   localparam logic [3:0]          c_flush_last = 4'(MM_ROWS - 1);
   localparam logic [1:0]          c_grp_last   = 2'(MM_GROUPS - 1);

   mm_state_t                     r_state;
   mm_state_t                     w_state_nxt;
   logic [MM_IDX_W-1:0]           r_idx;
   logic [3:0]                    r_ph;
   logic [1:0]                    r_grp;
   logic                          r_alu_en;
   logic                          r_seq_err;
   logic                          w_alu_en_nxt;
   logic                          w_accept;
   logic                          w_start_acc;
   logic                          w_cap_en;
   logic [MM_ROWS-1:0][MU_W-1:0]  w_mu;

   assign w_accept    = in_valid & in_ready;
   assign w_start_acc = (r_state == S_IDLE) & start;
   assign w_cap_en    = (r_state == S_COMPUTE) & (r_ph == c_ph_last);
   assign w_mu        = {mu4, mu3, mu2, mu1};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:    if (start) w_state_nxt = S_LOAD;
         S_LOAD:    if (w_accept && (r_idx == c_last_idx)) w_state_nxt = S_COMPUTE;
         S_COMPUTE: if ((r_ph == c_ph_last) && (r_grp == c_grp_last)) w_state_nxt = S_FLUSH;
         S_FLUSH:   if (r_ph == c_flush_last) w_state_nxt = S_DONE;
         S_DONE:    w_state_nxt = S_IDLE;
         default:   w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      busy     = 1'b1;
      done     = 1'b0;
      case (r_state)
         S_IDLE:  busy     = 1'b0;
         S_LOAD:  in_ready = 1'b1;
         S_DONE:  done     = 1'b1;
         default: ;
      endcase
      // Enable for the coming cycle: every compute phase except the clear phase.
      w_alu_en_nxt = (w_state_nxt == S_COMPUTE) &&
                     !((r_state == S_COMPUTE) && (r_ph == c_ph_chk));
   end

   // r_ph doubles as the flush-cycle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_idx <= '0;
         r_ph  <= 4'd0;
         r_grp <= 2'd0;
      end else begin
         if (r_state == S_IDLE) r_idx <= '0;
         else if (w_accept)     r_idx <= r_idx + 1'b1;
         case (r_state)
            S_COMPUTE: begin
               if (r_ph == c_ph_last) begin
                  r_ph  <= 4'd0;
                  r_grp <= r_grp + 2'd1;
               end else begin
                  r_ph  <= r_ph + 4'd1;
               end
            end
            S_FLUSH: r_ph <= r_ph + 4'd1;
            default: begin
               r_ph  <= 4'd0;
               r_grp <= 2'd0;
            end
         endcase
      end
   end

   // The ALU must flag results exactly on the last accumulate phase.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_alu_en  <= 1'b0;
         r_seq_err <= 1'b0;
      end else begin
         r_alu_en <= w_alu_en_nxt;
         if (w_start_acc)
            r_seq_err <= 1'b0;
         else if (r_alu_en && (four_results_ready != (r_ph == c_ph_chk)))
            r_seq_err <= 1'b1;
      end
   end

   assign alu_en    = r_alu_en;
   assign seq_err   = r_seq_err;
   assign buf_we    = w_accept;
   assign buf_row   = w_accept ? r_idx[4:3] : 2'd0;
   assign buf_col   = w_accept ? r_idx[2:0] : 3'd0;
   assign buf_wdata = w_accept ? in_data : '0;

   mm_result_writer #(
      .MU_W (MU_W)
   ) u_writer (
      .clk       (clk),
      .rst       (rst),
      .cap_en    (w_cap_en),
      .cap_grp   (r_grp),
      .cap_data  (w_mu),
      .res_we    (res_we),
      .res_addr  (res_addr),
      .res_wdata (res_wdata)
   );

endmodule
`default_nettype wire
